fft_w8_twiddle_mult: RTL and testbench
======================================

Name: fft_w8_twiddle_mult

Overview:
- Pipelined complex multiplier applying any eighth-root twiddle W8^k = e^(-j*2*pi*k/8), k = 0..7, to a signed fixed-point sample.
- Generalises the two-mode (W8^1 / W8^3) combinational rotator: parametrised width and fraction, all eight rotations, rounding, optional saturation, a valid/ready handshake and backpressure.
- Sits between radix-8/radix-2^3 butterfly stages of the FFT datapath.

Parameters:
- DATA_W, 16, sample width per component (signed two's complement).
- FRAC_W, 8, fractional bits (format Q(DATA_W-FRAC_W).FRAC_W).
- COEF, 181, unsigned round(2^FRAC_W/sqrt(2)); must be < 2^FRAC_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept the input this cycle.
- in_real  in  DATA_W  input real part, signed.
- in_imag  in  DATA_W  input imaginary part, signed.
- in_k  in  3  twiddle exponent k.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the output.
- out_real  out  DATA_W  result real part, signed.
- out_imag  out  DATA_W  result imaginary part, signed.
- out_ovf  out  1  this output's real or imaginary part exceeded the DATA_W range.

Behaviour:
- Reset: all stage valid bits are 0, so out_valid=0. out_real, out_imag and out_ovf are 0. in_ready=1 while rst is deasserted with the pipeline empty. Reset mid-stream discards all in-flight samples.
- Handshake: transfer on valid&&ready at each port. Global advance en = !out_valid || out_ready; in_ready = en. On en, every stage shifts by one; a stage with no valid data loads a bubble.
- Throughput is 1 sample/cycle. Latency is exactly 3 cycles from input acceptance to out_valid when out_ready=1. At most 3 samples are held; none are lost or duplicated under any out_ready pattern.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Stage 1 (pre-add), widths DATA_W+1, registered with k:
  - odd k: sr = re + im, si = im - re.
  - even k: sr = re, si = im, sign-extended.
- Stage 2 (scale), widths DATA_W+FRAC_W+2:
  - odd k: p = s*COEF (COEF treated as positive signed), then round-half-up: (p + 2^(FRAC_W-1)) >>> FRAC_W.
  - even k: pass through unscaled.
  - Both produce DATA_W+2-bit values pr, pi.
- Stage 3 (rotate, saturate, register), m = k[2:1]:
  - m=0: (pr, pi)
  - m=1 (-j): (pi, -pr)
  - m=2: (-pr, -pi)
  - m=3 (+j): (-pi, pr)
  - Then reduce to DATA_W per the optional feature. out_ovf=1 if either component lies outside [-2^(DATA_W-1), 2^(DATA_W-1)-1] before reduction.
- Even k is exact, apart from negating the minimum value.

Optional Feature:
- Macro FFT_TWID_SAT_EN.
- Defined: out-of-range components clamp to the DATA_W signed max/min.
- Undefined: keep the low DATA_W bits (wrap).
- out_ovf behaves identically in both builds.

Decomposition:
- Shared package fft_pkg holds:
  - COEF_W8 = 181 for FRAC_W=8;
  - the rotation encoding for m (ROT_0, ROT_NJ, ROT_NEG, ROT_PJ);
  - a complex-sample struct typedef parametrised on DATA_W.
- One sub-module, fft_rot_sat: the stage-3 combinational rotate, range check and saturate/wrap. It is reused by the butterfly.

Test Plan:
- (256,0), k=1, out_ready=1 -> after 3 cycles (181,-181), ovf=0.
- (256,0), k=2 -> (0,-256); k=3 -> (-181,-181); k=6 -> (0,256).
- (-32768,0), k=4 -> ovf=1; SAT build (32767,0), wrap build (-32768,0).
- (32767,32767), k=1 -> real 46335 pre-reduction; SAT build (32767,0), wrap build (-19201,0); ovf=1.
- Back-to-back 8 samples k=0..7 with out_ready low for cycles 2-6 -> in_ready drops once 3 are held; all 8 outputs appear in order, values correct, held stable while stalled.
- Assert rst with 2 samples in flight -> out_valid=0 immediately; outputs 0; no stale samples emerge after release.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: twiddle constant, rotation encoding, complex sample type.
package fft_pkg;

    // round(2^8 / sqrt(2)) for an 8-bit fraction
    localparam int COEF_W8    = 181;
    localparam int FFT_DATA_W = 16;

    // Quarter-turn rotation applied after scaling: multiply by 1, -j, -1, +j
    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_NJ  = 2'd1,
        ROT_NEG = 2'd2,
        ROT_PJ  = 2'd3
    } rot_t;

    typedef struct packed {
        logic signed [FFT_DATA_W-1:0] re;
        logic signed [FFT_DATA_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_rot_sat.sv
// Quarter-turn rotation followed by range check and reduction to DATA_W bits.
// Define FFT_TWID_SAT_EN to clamp out-of-range components; otherwise they wrap.
module fft_rot_sat
    import fft_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W+1:0] re_i,
    input  logic signed [DATA_W+1:0] im_i,
    input  rot_t                     rot_i,
    output logic signed [DATA_W-1:0] re_o,
    output logic signed [DATA_W-1:0] im_o,
    output logic                     ovf_o
);
    localparam int RW = DATA_W + 2;

    // In range only when the top three bits are all copies of the sign
    function automatic logic out_of_range(input logic signed [RW-1:0] x);
        return !((&x[RW-1:DATA_W-1]) || !(|x[RW-1:DATA_W-1]));
    endfunction

    function automatic logic signed [DATA_W-1:0] reduce(input logic signed [RW-1:0] x);
`ifdef FFT_TWID_SAT_EN
        if (out_of_range(x)) begin
            return x[RW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
`endif
        return x[DATA_W-1:0];
    endfunction

    logic signed [RW-1:0] rr;
    logic signed [RW-1:0] ri;

    always_comb begin
        rr = re_i;
        ri = im_i;
        case (rot_i)
            ROT_0:   begin rr =  re_i; ri =  im_i; end
            ROT_NJ:  begin rr =  im_i; ri = -re_i; end
            ROT_NEG: begin rr = -re_i; ri = -im_i; end
            ROT_PJ:  begin rr = -im_i; ri =  re_i; end
            default: begin rr =  re_i; ri =  im_i; end
        endcase
    end

    assign re_o  = reduce(rr);
    assign im_o  = reduce(ri);
    assign ovf_o = out_of_range(rr) || out_of_range(ri);

endmodule

// File: rtl/fft_w8_twiddle_mult.sv
// Three-stage W8^k twiddle multiplier (pre-add, 1/sqrt(2) scale with rounding, rotate/reduce)
// with a valid/ready handshake. Define FFT_TWID_SAT_EN for saturating instead of wrapping output.
module fft_w8_twiddle_mult
    import fft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int COEF   = COEF_W8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_real,
    input  logic signed [DATA_W-1:0] in_imag,
    input  logic [2:0]               in_k,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_real,
    output logic signed [DATA_W-1:0] out_imag,
    output logic                     out_ovf
);
    localparam int SW = DATA_W + 1;
    localparam int PW = DATA_W + FRAC_W + 2;
    localparam int RW = DATA_W + 2;
    localparam logic signed [PW-1:0] COEF_S = PW'(COEF);
    localparam logic signed [PW-1:0] HALF   = {{(PW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

    function automatic logic signed [RW-1:0] scale_round(input logic signed [SW-1:0] s);
        logic signed [PW-1:0] p;
        p = PW'(s) * COEF_S + HALF;
        return RW'(p >>> FRAC_W);
    endfunction

    logic en;
    logic vld_p0_q, vld_p1_q, vld_p2_q;

    // The whole pipe advances together whenever the output slot is free or being taken
    assign en        = !vld_p2_q || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_p2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
        end else if (en) begin
            vld_p0_q <= in_valid;
            vld_p1_q <= vld_p0_q;
            vld_p2_q <= vld_p1_q;
        end
    end

    // Stage p0: pre-add
    logic signed [SW-1:0] re_ext, im_ext;
    logic signed [SW-1:0] sr_p0_d, si_p0_d, sr_p0_q, si_p0_q;
    logic [2:0]           k_p0_q;

    always_comb begin
        re_ext  = {in_real[DATA_W-1], in_real};
        im_ext  = {in_imag[DATA_W-1], in_imag};
        sr_p0_d = re_ext;
        si_p0_d = im_ext;
        if (in_k[0]) begin
            sr_p0_d = re_ext + im_ext;
            si_p0_d = im_ext - re_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            sr_p0_q <= sr_p0_d;
            si_p0_q <= si_p0_d;
            k_p0_q  <= in_k;
        end
    end

    // Stage p1: scale odd k by 1/sqrt(2)
    logic signed [RW-1:0] pr_p1_d, pi_p1_d, pr_p1_q, pi_p1_q;
    rot_t                 rot_p1_q;

    always_comb begin
        pr_p1_d = {sr_p0_q[SW-1], sr_p0_q};
        pi_p1_d = {si_p0_q[SW-1], si_p0_q};
        if (k_p0_q[0]) begin
            pr_p1_d = scale_round(sr_p0_q);
            pi_p1_d = scale_round(si_p0_q);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            pr_p1_q  <= pr_p1_d;
            pi_p1_q  <= pi_p1_d;
            rot_p1_q <= rot_t'(k_p0_q[2:1]);
        end
    end

    // Stage p2: rotate, range check, reduce
    logic signed [DATA_W-1:0] re_p2_d, im_p2_d, re_p2_q, im_p2_q;
    logic                     ovf_p2_d, ovf_p2_q;

    fft_rot_sat #(
        .DATA_W (DATA_W)
    ) u_rot_sat (
        .re_i   (pr_p1_q),
        .im_i   (pi_p1_q),
        .rot_i  (rot_p1_q),
        .re_o   (re_p2_d),
        .im_o   (im_p2_d),
        .ovf_o  (ovf_p2_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            re_p2_q  <= '0;
            im_p2_q  <= '0;
            ovf_p2_q <= 1'b0;
        end else if (en) begin
            re_p2_q  <= re_p2_d;
            im_p2_q  <= im_p2_d;
            ovf_p2_q <= ovf_p2_d;
        end
    end

    assign out_real = re_p2_q;
    assign out_imag = im_p2_q;
    assign out_ovf  = ovf_p2_q;

endmodule

// File: tb/tb_fft_w8_twiddle_mult.sv
// Scoreboard bench for fft_w8_twiddle_mult; build with FFT_TWID_SAT_EN to check the saturating variant.
module tb_fft_w8_twiddle_mult;
    import fft_pkg::*;

    typedef struct packed {
        cplx_t c;
        logic  ovf;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_real;
    logic signed [15:0] in_imag;
    logic [2:0]         in_k;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_real;
    logic signed [15:0] out_imag;
    logic               out_ovf;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fft_w8_twiddle_mult #(
        .DATA_W (16),
        .FRAC_W (8),
        .COEF   (181)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_ovf   (out_ovf)
    );

    function automatic exp_t mk(input int re, input int im, input logic ovf);
        exp_t e;
        e.c.re = 16'(re);
        e.c.im = 16'(im);
        e.ovf  = ovf;
        return e;
    endfunction

    // Reference: exact integer arithmetic of the twiddle product
    function automatic exp_t model(input int re, input int im, input logic [2:0] k);
        int   pr, pi, rr, ri;
        logic ovf;
        if (k[0]) begin
            pr = ((re + im) * COEF_W8 + 128) >>> 8;
            pi = ((im - re) * COEF_W8 + 128) >>> 8;
        end else begin
            pr = re;
            pi = im;
        end
        case (k[2:1])
            2'd0:    begin rr =  pr; ri =  pi; end
            2'd1:    begin rr =  pi; ri = -pr; end
            2'd2:    begin rr = -pr; ri = -pi; end
            default: begin rr = -pi; ri =  pr; end
        endcase
        ovf = (rr > 32767) || (rr < -32768) || (ri > 32767) || (ri < -32768);
`ifdef FFT_TWID_SAT_EN
        rr = (rr > 32767) ? 32767 : ((rr < -32768) ? -32768 : rr);
        ri = (ri > 32767) ? 32767 : ((ri < -32768) ? -32768 : ri);
`endif
        return mk(rr, ri, ovf);
    endfunction

    // Present one sample (called just after a rising edge); leaves in_valid high.
    task automatic push_in(input logic signed [15:0] re, input logic signed [15:0] im,
                           input logic [2:0] k, input exp_t e);
        int w = 0;
        in_valid = 1'b1;
        in_real  = re;
        in_imag  = im;
        in_k     = k;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
            w++;
            if (w > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready=%0b want 1", in_ready);
                return;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        checks++;
        if (out_real !== 16'sd0 || out_imag !== 16'sd0) begin
            errors++; $display("FAIL reset_data: got (%0d,%0d) want (0,0)", out_real, out_imag);
        end
        checks++;
        if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b want 0", out_ovf); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_latency();
        exp_t e;
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_in(16'sd256, 16'sd0, 3'd1, mk(181, -181, 1'b0));
        in_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (i == 3)) begin
                errors++; $display("FAIL latency_valid_%0d: got %0b want %0b", i, out_valid, (i == 3));
            end
        end
        e = sb.pop_front();
        checks++;
        if (out_real !== e.c.re || out_imag !== e.c.im || out_ovf !== e.ovf) begin
            errors++;
            $display("FAIL latency_data: got (%0d,%0d,%0b) want (%0d,%0d,%0b)",
                     out_real, out_imag, out_ovf, e.c.re, e.c.im, e.ovf);
        end
    endtask

    task automatic test_directed();
        int   re_t[6] = '{256, 256, 256, 256, -32768, 32767};
        int   im_t[6] = '{0, 0, 0, 0, 0, 32767};
        int   k_t[6]  = '{1, 2, 3, 6, 4, 1};
`ifdef FFT_TWID_SAT_EN
        int   er_t[6] = '{181, 0, -181, 0, 32767, 32767};
`else
        int   er_t[6] = '{181, 0, -181, 0, -32768, -19201};
`endif
        int   ei_t[6] = '{-181, -256, -181, 256, 0, 0};
        logic eo_t[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        @(posedge clk); #1;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    push_in(16'(re_t[i]), 16'(im_t[i]), 3'(k_t[i]), mk(er_t[i], ei_t[i], eo_t[i]));
                in_valid = 1'b0;
            end
            begin
                exp_t e;
                int   got = 0;
                for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        checks++;
                        if (sb.size() == 0) begin
                            errors++; $display("FAIL directed_extra: got unexpected output (%0d,%0d)", out_real, out_imag);
                        end else begin
                            e = sb.pop_front();
                            if (out_real !== e.c.re || out_imag !== e.c.im || out_ovf !== e.ovf) begin
                                errors++;
                                $display("FAIL directed_%0d: got (%0d,%0d,%0b) want (%0d,%0d,%0b)",
                                         got, out_real, out_imag, out_ovf, e.c.re, e.c.im, e.ovf);
                            end
                        end
                        got++;
                    end
                end
                checks++;
                if (got != 6) begin errors++; $display("FAIL directed_count: got %0d want 6", got); end
            end
        join
    endtask

    task automatic test_back_to_back();
        logic saw_block = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    push_in(16'(4000 * i - 14000), 16'(9000 - 2500 * i), 3'(i),
                            model(4000 * i - 14000, 9000 - 2500 * i, 3'(i)));
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 2 && c <= 6);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
            begin
                exp_t               e;
                int                 got = 0;
                logic               hv  = 1'b0;
                logic signed [15:0] hr, hi;
                for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
                    @(negedge clk);
                    if (hv && out_valid) begin
                        checks++;
                        if (out_real !== hr || out_imag !== hi) begin
                            errors++; $display("FAIL b2b_hold: got (%0d,%0d) want (%0d,%0d)", out_real, out_imag, hr, hi);
                        end
                    end
                    hv = 1'b0;
                    if (out_valid && !out_ready) begin
                        hv = 1'b1; hr = out_real; hi = out_imag;
                        saw_block = 1'b1;
                        checks++;
                        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready: got %0b want 0", in_ready); end
                    end else if (out_valid && out_ready) begin
                        checks++;
                        if (sb.size() == 0) begin
                            errors++; $display("FAIL b2b_extra: got unexpected output (%0d,%0d)", out_real, out_imag);
                        end else begin
                            e = sb.pop_front();
                            if (out_real !== e.c.re || out_imag !== e.c.im || out_ovf !== e.ovf) begin
                                errors++;
                                $display("FAIL b2b_%0d: got (%0d,%0d,%0b) want (%0d,%0d,%0b)",
                                         got, out_real, out_imag, out_ovf, e.c.re, e.c.im, e.ovf);
                            end
                        end
                        got++;
                    end
                end
                checks++;
                if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", got); end
            end
        join
        checks++;
        if (saw_block !== 1'b1) begin errors++; $display("FAIL b2b_backpressure: stall seen=%0b want 1", saw_block); end
    endtask

    task automatic test_random();
        logic done = 1'b0;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic signed [15:0] r, m;
                    logic [2:0]         k;
                    r = 16'($urandom);
                    m = 16'($urandom);
                    k = 3'($urandom);
                    push_in(r, m, k, model(r, m, k));
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 400 && !done; c++) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
            begin
                exp_t e;
                int   got = 0;
                for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        checks++;
                        if (sb.size() == 0) begin
                            errors++; $display("FAIL random_extra: got unexpected output (%0d,%0d)", out_real, out_imag);
                        end else begin
                            e = sb.pop_front();
                            if (out_real !== e.c.re || out_imag !== e.c.im || out_ovf !== e.ovf) begin
                                errors++;
                                $display("FAIL random_%0d: got (%0d,%0d,%0b) want (%0d,%0d,%0b)",
                                         got, out_real, out_imag, out_ovf, e.c.re, e.c.im, e.ovf);
                            end
                        end
                        got++;
                    end
                end
                done = 1'b1;
                checks++;
                if (got != 40) begin errors++; $display("FAIL random_count: got %0d want 40", got); end
            end
        join
    endtask

    task automatic test_reset_midstream();
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_in(16'sd256, 16'sd0, 3'd1, mk(181, -181, 1'b0));
        push_in(16'sd100, 16'sd50, 3'd2, mk(50, -100, 1'b0));
        in_valid = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (out_valid !== 1'b1 || out_real !== 16'sd181) begin
            errors++; $display("FAIL midrst_pre: got valid=%0b real=%0d want valid=1 real=181", out_valid, out_real);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %0b want 0", out_valid); end
        checks++;
        if (out_real !== 16'sd0 || out_imag !== 16'sd0 || out_ovf !== 1'b0) begin
            errors++; $display("FAIL midrst_data: got (%0d,%0d,%0b) want (0,0,0)", out_real, out_imag, out_ovf);
        end
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale_%0d: out_valid=%0b want 0", i, out_valid); end
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %0b want 1", in_ready); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid  = 1'b0;
        in_real   = '0;
        in_imag   = '0;
        in_k      = '0;
        out_ready = 1'b1;
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
